// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with an accumulator, iterative
// one-bit-per-cycle shifter, and valid/ready handshakes on both sides.
// Non-shift ops and shifts by 0/1 go IDLE -> EXEC -> DONE. Longer shifts
// go IDLE -> SHIFT -> DONE, with one shift step per cycle.
module alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         mode,
  input  logic               use_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_n,
  output logic               flag_v
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_NOT = 3'b011,
    OP_SUB = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state;
  op_e                op_q;      // latched operation
  logic [WIDTH-1:0]   work;      // operand A, and the shift register in SHIFT
  logic [WIDTH-1:0]   b_q;       // latched operand B
  logic [SHAMT_W-1:0] cnt;       // shift amount / remaining shift steps
  logic [WIDTH-1:0]   acc;

  // Operand selection at the accept edge
  logic [WIDTH-1:0]   a_sel;
  logic [SHAMT_W-1:0] shamt_in;
  logic               long_shift;

  // One-bit shift step of work, direction from the latched op
  logic [WIDTH-1:0]   step_work;
  logic               step_out;

  // ALU result for the EXEC state
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;

  // Decode of the incoming command: operand A source and whether it is a multi-cycle shift
  always_comb begin
    a_sel      = use_acc ? acc : a;
    shamt_in   = b[SHAMT_W-1:0];
    long_shift = ((mode == OP_SHL) || (mode == OP_SHR)) && (shamt_in > SHAMT_W'(1));
  end

  // Single shift step used by both the SHIFT loop and the shift-by-one case
  always_comb begin
    if (op_q == OP_SHL) begin
      step_work = {work[WIDTH-2:0], 1'b0};
      step_out  = work[WIDTH-1];
    end else begin
      step_work = {1'b0, work[WIDTH-1:1]};
      step_out  = work[0];
    end
  end

  // Single-cycle ALU evaluated from the latched operands
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    sum_ext  = {1'b0, work} + {1'b0, b_q};
    diff_ext = {1'b0, work} - {1'b0, b_q};
    case (op_q)
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (work[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != work[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];  // borrow: set iff work < b_q unsigned
        alu_v   = (work[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != work[WIDTH-1]);
      end
      OP_AND: alu_res = work & b_q;
      OP_OR:  alu_res = work | b_q;
      OP_XOR: alu_res = work ^ b_q;
      OP_NOT: alu_res = ~work;
      OP_SHL, OP_SHR: begin
        // Only shift amounts of 0 or 1 reach EXEC
        if (cnt == '0) begin
          alu_res = work;
        end else begin
          alu_res = step_work;
          alu_c   = step_out;
        end
      end
      default: alu_res = '0;
    endcase
  end

  // Control FSM with registered handshake, result, flag and accumulator outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_ADD;
      work      <= '0;
      b_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= op_e'(mode);
            work     <= a_sel;
            b_q      <= b;
            cnt      <= shamt_in;
            in_ready <= 1'b0;
            state    <= long_shift ? S_SHIFT : S_EXEC;
          end
        end
        S_EXEC: begin
          result    <= alu_res;
          acc       <= alu_res;
          flag_z    <= (alu_res == '0);
          flag_n    <= alu_res[WIDTH-1];
          flag_c    <= alu_c;
          flag_v    <= alu_v;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_SHIFT: begin
          work <= step_work;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result    <= step_work;
            acc       <= step_work;
            flag_z    <= (step_work == '0);
            flag_n    <= step_work[WIDTH-1];
            flag_c    <= step_out;
            flag_v    <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
